// File: rtl/pipeline_types.sv
// Shared edge-pulse struct and debounce FSM state encoding for the debounce bank.
package pipeline_types;

    typedef struct packed {
        logic rising;
        logic falling;
    } edges_t;

    localparam edges_t EDGES_RESET = '{rising: 1'b0, falling: 1'b0};

    typedef enum logic [1:0] {
        ST_LO,
        ST_CHK_HI,
        ST_HI,
        ST_CHK_LO
    } deb_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One channel: SYNC_STAGES synchronizer plus counter debounce FSM; level moves SYNC_STAGES+DEBOUNCE_CYCLES edges after input.
// Long-press counter is built only when DEBOUNCE_BANK_HOLD_EN is defined.
module debounce_channel
    import pipeline_types::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 1024
) (
    input  logic   i_clk,
    input  logic   i_reset_n,
    input  logic   i_signal_async,
    output logic   o_level,
    output edges_t o_edges,
    output logic   o_hold
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1) begin : g_bad_param
        $error("debounce_channel: parameter out of range");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    deb_state_e             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    edges_t                 edges_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_signal_async};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // The counter restarts on every state change, so it never needs to wrap.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= ST_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            edges_q <= EDGES_RESET;
        end else begin
            edges_q <= EDGES_RESET;
            case (state_q)
                ST_LO: begin
                    if (synced) begin
                        state_q <= ST_CHK_HI;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                ST_CHK_HI: begin
                    if (!synced) begin
                        state_q <= ST_LO;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q         <= ST_HI;
                        cnt_q           <= '0;
                        level_q         <= 1'b1;
                        edges_q.rising  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_HI: begin
                    if (!synced) begin
                        state_q <= ST_CHK_LO;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                ST_CHK_LO: begin
                    if (synced) begin
                        state_q <= ST_HI;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q         <= ST_LO;
                        cnt_q           <= '0;
                        level_q         <= 1'b0;
                        edges_q.falling <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_LO;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign o_level = level_q;
    assign o_edges = edges_q;

`ifdef DEBOUNCE_BANK_HOLD_EN
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              armed_q;
    logic              hold_q;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (state_q != ST_HI) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
    end

    // A bounce back from ST_CHK_LO restarts the count but stays disarmed until a real fall.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            hold_cnt_q <= '0;
            armed_q    <= 1'b1;
            hold_q     <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            hold_q     <= 1'b0;
            if (armed_q && state_q == ST_HI && hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                hold_q  <= 1'b1;
                armed_q <= 1'b0;
            end else if (edges_q.falling) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign o_hold = hold_q;
`else
    assign o_hold = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// NUM_CH independent debounce channels plus a wake strobe OR-ing every edge pulse in the same cycle.
// Long-press outputs are live only when DEBOUNCE_BANK_HOLD_EN is defined.
module debounce_bank
    import pipeline_types::*;
#(
    parameter int NUM_CH          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 1024
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [NUM_CH-1:0] i_signal_async,
    output logic [NUM_CH-1:0] o_signal_syncd,
    output edges_t            o_edges [NUM_CH],
    output logic              o_any_edge,
    output logic [NUM_CH-1:0] o_hold
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES)
        ) u_ch (
            .i_clk          (i_clk),
            .i_reset_n      (i_reset_n),
            .i_signal_async (i_signal_async[g]),
            .o_level        (o_signal_syncd[g]),
            .o_edges        (o_edges[g]),
            .o_hold         (o_hold[g])
        );
    end

    always_comb begin
        o_any_edge = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            o_any_edge = o_any_edge | o_edges[i].rising | o_edges[i].falling;
        end
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed and random stimulus for debounce_bank against a sample-window reference model.
module tb_debounce_bank;
    import pipeline_types::*;

    localparam int NUM_CH = 4;
    localparam int SYNC   = 2;
    localparam int DEB    = 4;
    localparam int HOLD   = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH-1:0] sig = '0;
    logic [NUM_CH-1:0] syncd;
    edges_t            edg [NUM_CH];
    logic              any_edge;
    logic [NUM_CH-1:0] hold;

    always #5 clk = ~clk;

    debounce_bank #(
        .NUM_CH          (NUM_CH),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_signal_async (sig),
        .o_signal_syncd (syncd),
        .o_edges        (edg),
        .o_any_edge     (any_edge),
        .o_hold         (hold)
    );

    int tests = 0;
    int fails = 0;

    // Model: the FSM observes the raw sample from SYNC edges ago; the level flips
    // once the last DEB observed samples all disagree with it.
    bit pipe [NUM_CH][$];
    bit win  [NUM_CH][$];
    bit m_lvl   [NUM_CH];
    bit m_armed [NUM_CH];
    int m_hirun [NUM_CH];
    logic [NUM_CH-1:0] e_lvl, e_rise, e_fall, e_hold;

`ifdef DEBOUNCE_BANK_HOLD_EN
    localparam bit HOLD_ON = 1'b1;
`else
    localparam bit HOLD_ON = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic [NUM_CH-1:0] raw, input logic rstn);
        e_rise = '0;
        e_fall = '0;
        e_hold = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!rstn) begin
                pipe[c].delete();
                for (int k = 0; k < SYNC; k++) pipe[c].push_back(1'b0);
                win[c].delete();
                m_lvl[c]   = 1'b0;
                m_armed[c] = 1'b1;
                m_hirun[c] = 0;
            end else begin
                bit obs;
                bit flip;
                obs = pipe[c].pop_front();
                pipe[c].push_back(raw[c]);
                win[c].push_back(obs);
                if (win[c].size() > DEB) void'(win[c].pop_front());
                flip = (win[c].size() == DEB);
                for (int k = 0; k < win[c].size(); k++)
                    if (win[c][k] == m_lvl[c]) flip = 1'b0;
                if (m_hirun[c] == HOLD && m_armed[c]) begin
                    e_hold[c]  = 1'b1;
                    m_armed[c] = 1'b0;
                end
                if (flip) begin
                    if (m_lvl[c]) begin
                        e_fall[c]  = 1'b1;
                        m_armed[c] = 1'b1;
                    end else begin
                        e_rise[c] = 1'b1;
                    end
                    m_lvl[c] = !m_lvl[c];
                end
                m_hirun[c] = (m_lvl[c] && obs) ? m_hirun[c] + 1 : 0;
            end
            e_lvl[c] = m_lvl[c];
        end
    endtask

    task automatic tick(input logic [NUM_CH-1:0] raw, input logic rstn);
        logic [NUM_CH-1:0] r, f;
        sig   = raw;
        rst_n = rstn;
        @(posedge clk);
        model_edge(raw, rstn);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            r[c] = edg[c].rising;
            f[c] = edg[c].falling;
        end
        chk("level",   32'(syncd), 32'(e_lvl));
        chk("rising",  32'(r), 32'(e_rise));
        chk("falling", 32'(f), 32'(e_fall));
        chk("any_edge", 32'(any_edge), 32'(|(e_rise | e_fall)));
        chk("hold",    32'(hold), HOLD_ON ? 32'(e_hold) : 32'd0);
    endtask

    initial begin
        int rise_at, any_cnt, pulse_cnt, hold_at, hold_cnt;
        logic [NUM_CH-1:0] rnd;

        // Reset state
        repeat (3) tick(4'b0000, 1'b0);
        chk("rst_level", 32'(syncd), 32'd0);
        chk("rst_any", 32'(any_edge), 32'd0);
        chk("rst_hold", 32'(hold), 32'd0);

        // ch0 rise: pulse on the 6th edge, wake strobe in the same cycle
        rise_at = 0; any_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(4'b0001, 1'b1);
            if (edg[0].rising === 1'b1) rise_at = i;
            if (any_edge === 1'b1) any_cnt++;
        end
        chk("ch0_rise_edge", 32'(rise_at), 32'd6);
        chk("ch0_any_cnt", 32'(any_cnt), 32'd1);
        chk("ch0_level", 32'(syncd[0]), 32'd1);

        // ch1 glitch of 3 synced samples is rejected
        pulse_cnt = 0;
        repeat (3) tick(4'b0011, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick(4'b0001, 1'b1);
            if (edg[1].rising === 1'b1 || edg[1].falling === 1'b1) pulse_cnt++;
        end
        chk("ch1_glitch_pulses", 32'(pulse_cnt), 32'd0);
        chk("ch1_glitch_level", 32'(syncd[1]), 32'd0);
        chk("ch1_glitch_state", 32'(dut.g_ch[1].u_ch.state_q), 32'(ST_LO));

        // ch2 toggles 1,0 then holds 1
        tick(4'b0101, 1'b1);
        tick(4'b0001, 1'b1);
        rise_at = 0; pulse_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(4'b0101, 1'b1);
            if (edg[2].rising === 1'b1) begin
                rise_at = i;
                pulse_cnt++;
            end
        end
        chk("ch2_rise_edge", 32'(rise_at), 32'd6);
        chk("ch2_rise_cnt", 32'(pulse_cnt), 32'd1);

        // ch0 and ch3 rise together
        repeat (8) tick(4'b0000, 1'b1);
        any_cnt = 0; pulse_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(4'b1001, 1'b1);
            if (any_edge === 1'b1) any_cnt++;
            if (edg[0].rising === 1'b1 && edg[3].rising === 1'b1) pulse_cnt++;
        end
        chk("ch03_joint_rise", 32'(pulse_cnt), 32'd1);
        chk("ch03_any_cnt", 32'(any_cnt), 32'd1);

        // Reset in the middle of ch1 debounce
        repeat (8) tick(4'b0000, 1'b1);
        repeat (4) tick(4'b0010, 1'b1);
        chk("ch1_mid_state", 32'(dut.g_ch[1].u_ch.state_q), 32'(ST_CHK_HI));
        chk("ch1_mid_cnt", 32'(dut.g_ch[1].u_ch.cnt_q), 32'd2);
        tick(4'b0010, 1'b0);
        chk("mid_rst_level", 32'(syncd), 32'd0);
        rise_at = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(4'b0010, 1'b1);
            if (edg[1].rising === 1'b1) rise_at = i;
        end
        chk("ch1_post_rst_rise", 32'(rise_at), 32'd6);

        // Long press on ch0, then a bounce, then a real fall and rise
        repeat (8) tick(4'b0000, 1'b1);
        rise_at = 0; hold_at = 0; hold_cnt = 0;
        for (int i = 1; i <= 24; i++) begin
            tick(4'b0001, 1'b1);
            if (edg[0].rising === 1'b1) rise_at = i;
            if (hold[0] === 1'b1) begin
                hold_at = i;
                hold_cnt++;
            end
        end
        chk("hold_cnt_first", 32'(hold_cnt), HOLD_ON ? 32'd1 : 32'd0);
        if (HOLD_ON) chk("hold_delay", 32'(hold_at - rise_at), 32'(HOLD));
        hold_cnt = 0;
        repeat (2) tick(4'b0000, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick(4'b0001, 1'b1);
            if (hold[0] === 1'b1) hold_cnt++;
        end
        chk("hold_after_bounce", 32'(hold_cnt), 32'd0);
        chk("bounce_level", 32'(syncd[0]), 32'd1);
        hold_cnt = 0;
        repeat (8) tick(4'b0000, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick(4'b0001, 1'b1);
            if (hold[0] === 1'b1) hold_cnt++;
        end
        chk("hold_rearmed", 32'(hold_cnt), HOLD_ON ? 32'd1 : 32'd0);

        // Random bursts and occasional resets against the model
        rnd = '0;
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, 5) == 0) rnd[c] = ~rnd[c];
            tick(rnd, ($urandom_range(0, 199) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
